pipeline_stage1: RTL and testbench



---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/pipeline_stage1_len_decode.sv | 11 +
 rtl/pipeline_stage1.sv | 141 ++++++++++++++
 tb/tb_pipeline_stage1.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the CPU pipeline: stage-1 state encoding, the bubble
// opcode default and the opcode-length rule used by decode and trace logic.
package pipeline_pkg;

  localparam logic [7:0] NOP_OPCODE_DEFAULT = 8'h00;

  typedef logic [1:0] state_t;

  localparam state_t S_OPCODE = 2'd0;
  localparam state_t S_IMM_LO = 2'd1;
  localparam state_t S_IMM_HI = 2'd2;

  // Opcode bits [7:6] give the number of immediate bytes that follow.
  function automatic logic [1:0] imm_count(input logic [1:0] len_field);
    case (len_field)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage1_len_decode.sv
// Combinational opcode-length decoder: top two opcode bits -> immediate bytes.
module pipeline_stage1_len_decode
  import pipeline_pkg::*;
(
  input  logic [1:0] len_field,
  output logic [1:0] count
);

  assign count = imm_count(len_field);

endmodule

// File: rtl/pipeline_stage1.sv
// Pipeline stage 1: gathers 0-2 immediate bytes after each opcode and hands a
// complete instruction to stage 2. Optional macro PIPELINE_STAGE1_BUBBLE_COUNT_EN
// adds a saturating count of bubble cycles on Pipe1BubbleCount.
module pipeline_stage1
  import pipeline_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] NOP_OPCODE = DATA_W'(NOP_OPCODE_DEFAULT)
) (
  input  logic                ClockIn,
  input  logic                ResetIn,
  input  logic                BusRequest,
  input  logic                Flush,
  input  logic [DATA_W-1:0]   Pipe0In,
  input  logic [DATA_W-1:0]   MEMDATA,
  output logic                FetchSurpress,
  output logic [DATA_W-1:0]   Pipe1Out,
  output logic [2*DATA_W-1:0] Pipe1Imm,
  output logic                Pipe1Valid
`ifdef PIPELINE_STAGE1_BUBBLE_COUNT_EN
  ,
  output logic [15:0]         Pipe1BubbleCount
`endif
);

  state_t              state, state_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   imm_lo_q, imm_lo_d;
  logic [1:0]          remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_d;
  logic [2*DATA_W-1:0] imm_d;
  logic                valid_d;
  logic [1:0]          len_count;

  pipeline_stage1_len_decode u_len_decode (
    .len_field (Pipe0In[DATA_W-1 -: 2]),
    .count     (len_count)
  );

  assign FetchSurpress = !ResetIn && (state != S_OPCODE);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    opcode_d    = opcode_q;
    imm_lo_d    = imm_lo_q;
    remaining_d = remaining_q;
    out_d       = Pipe1Out;
    imm_d       = Pipe1Imm;
    valid_d     = Pipe1Valid;

    if (Flush) begin
      state_d = S_OPCODE;
      out_d   = NOP_OPCODE;
      imm_d   = '0;
      valid_d = 1'b0;
    end else if (!BusRequest) begin
      out_d   = NOP_OPCODE;
      imm_d   = '0;
      valid_d = 1'b0;
      case (state)
        S_OPCODE: begin
          opcode_d    = Pipe0In;
          imm_lo_d    = '0;
          remaining_d = len_count;
          if (len_count == 2'd0) begin
            out_d   = Pipe0In;
            valid_d = 1'b1;
          end else begin
            state_d = S_IMM_LO;
          end
        end
        S_IMM_LO: begin
          imm_lo_d = MEMDATA;
          if (remaining_q == 2'd1) begin
            out_d       = opcode_q;
            imm_d       = {{DATA_W{1'b0}}, MEMDATA};
            valid_d     = 1'b1;
            remaining_d = 2'd0;
            state_d     = S_OPCODE;
          end else if (remaining_q == 2'd2) begin
            remaining_d = 2'd1;
            state_d     = S_IMM_HI;
          end else begin
            remaining_d = 2'd0;
            state_d     = S_OPCODE;
          end
        end
        S_IMM_HI: begin
          // Only a two-byte opcode can legally reach here; anything else is dropped.
          if (remaining_q == 2'd1) begin
            out_d   = opcode_q;
            imm_d   = {MEMDATA, imm_lo_q};
            valid_d = 1'b1;
          end
          remaining_d = 2'd0;
          state_d     = S_OPCODE;
        end
        default: begin
          remaining_d = 2'd0;
          state_d     = S_OPCODE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      state       <= S_OPCODE;
      opcode_q    <= NOP_OPCODE;
      imm_lo_q    <= '0;
      remaining_q <= 2'd0;
      Pipe1Out    <= NOP_OPCODE;
      Pipe1Imm    <= '0;
      Pipe1Valid  <= 1'b0;
    end else begin
      state       <= state_d;
      opcode_q    <= opcode_d;
      imm_lo_q    <= imm_lo_d;
      remaining_q <= remaining_d;
      Pipe1Out    <= out_d;
      Pipe1Imm    <= imm_d;
      Pipe1Valid  <= valid_d;
    end
  end

`ifdef PIPELINE_STAGE1_BUBBLE_COUNT_EN
  // Flush does not clear the count; only reset does.
  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      Pipe1BubbleCount <= 16'h0000;
    end else if (!BusRequest && !valid_d && (Pipe1BubbleCount != 16'hFFFF)) begin
      Pipe1BubbleCount <= Pipe1BubbleCount + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage1.sv
// Self-checking bench for pipeline_stage1: instruction-level model compared
// every cycle plus directed literal checks.
module tb_pipeline_stage1;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        bus_request;
  logic        flush;
  logic [7:0]  pipe0_in;
  logic [7:0]  memdata;
  logic        fetch_surpress;
  logic [7:0]  pipe1_out;
  logic [15:0] pipe1_imm;
  logic        pipe1_valid;
`ifdef PIPELINE_STAGE1_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  pipeline_stage1 dut (
    .ClockIn       (clock_in),
    .ResetIn       (reset_in),
    .BusRequest    (bus_request),
    .Flush         (flush),
    .Pipe0In       (pipe0_in),
    .MEMDATA       (memdata),
    .FetchSurpress (fetch_surpress),
    .Pipe1Out      (pipe1_out),
    .Pipe1Imm      (pipe1_imm),
    .Pipe1Valid    (pipe1_valid)
`ifdef PIPELINE_STAGE1_BUBBLE_COUNT_EN
    ,
    .Pipe1BubbleCount (bubble_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  function automatic int need_of(input logic [7:0] op);
    if (op[7:6] == 2'b01) return 1;
    if (op[7:6] == 2'b10) return 2;
    return 0;
  endfunction

  // Instruction-level model: an opcode either completes at once or waits for
  // its immediate bytes, which are collected in order from the memory bus.
  bit         m_busy;
  logic [7:0] m_op;
  int         m_need;
  int         m_got;
  logic [7:0] m_bytes [2];
  logic [7:0] m_out;
  logic [15:0] m_imm;
  bit         m_valid;

  always @(posedge clock_in) begin
    if (reset_in || flush) begin
      m_busy  <= 1'b0;
      m_out   <= 8'h00;
      m_imm   <= 16'h0000;
      m_valid <= 1'b0;
    end else if (!bus_request) begin
      if (!m_busy) begin
        if (need_of(pipe0_in) == 0) begin
          m_out   <= pipe0_in;
          m_imm   <= 16'h0000;
          m_valid <= 1'b1;
        end else begin
          m_busy  <= 1'b1;
          m_op    <= pipe0_in;
          m_need  <= need_of(pipe0_in);
          m_got   <= 0;
          m_out   <= 8'h00;
          m_valid <= 1'b0;
        end
      end else begin
        m_bytes[m_got] <= memdata;
        if (m_got + 1 == m_need) begin
          m_busy  <= 1'b0;
          m_out   <= m_op;
          m_valid <= 1'b1;
          m_imm   <= (m_need == 1) ? {8'h00, memdata} : {memdata, m_bytes[0]};
        end else begin
          m_got   <= m_got + 1;
          m_out   <= 8'h00;
          m_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge clock_in) begin
    if (cmp_en) begin
      check("cmp_fetch_surpress", 32'(fetch_surpress), 32'(m_busy && !reset_in));
      check("cmp_valid", 32'(pipe1_valid), 32'(m_valid));
      check("cmp_out", 32'(pipe1_out), 32'(m_out));
      if (m_valid) check("cmp_imm", 32'(pipe1_imm), 32'(m_imm));
    end
  end

  initial begin
    reset_in    = 1'b1;
    bus_request = 1'b0;
    flush       = 1'b0;
    pipe0_in    = 8'h05;
    memdata     = 8'h00;

    // Reset held two cycles with a live opcode on the input.
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_out", 32'(pipe1_out), 32'h00);
    check("rst_imm", 32'(pipe1_imm), 32'h0000);
    check("rst_valid", 32'(pipe1_valid), 32'h0);
    check("rst_fs", 32'(fetch_surpress), 32'h0);

    reset_in = 1'b0;
    tick();
    check("post_rst_valid", 32'(pipe1_valid), 32'h1);
    check("post_rst_out", 32'(pipe1_out), 32'h05);
    check("post_rst_imm", 32'(pipe1_imm), 32'h0000);

    // One-byte immediate.
    pipe0_in = 8'h42;
    tick();
    check("imm1_fs", 32'(fetch_surpress), 32'h1);
    check("imm1_bubble", 32'(pipe1_valid), 32'h0);
    pipe0_in = 8'h00;
    memdata  = 8'h7E;
    tick();
    check("imm1_valid", 32'(pipe1_valid), 32'h1);
    check("imm1_out", 32'(pipe1_out), 32'h42);
    check("imm1_imm", 32'(pipe1_imm), 32'h007E);
    check("imm1_fs_done", 32'(fetch_surpress), 32'h0);

    // Two-byte immediate.
    pipe0_in = 8'h81;
    tick();
    pipe0_in = 8'h00;
    memdata  = 8'h34;
    tick();
    check("imm2_fs", 32'(fetch_surpress), 32'h1);
    memdata = 8'h12;
    tick();
    check("imm2_valid", 32'(pipe1_valid), 32'h1);
    check("imm2_out", 32'(pipe1_out), 32'h81);
    check("imm2_imm", 32'(pipe1_imm), 32'h1234);

    // Same instruction with a three-cycle bus stall between the bytes.
    pipe0_in = 8'h81;
    tick();
    pipe0_in = 8'h00;
    memdata  = 8'h34;
    tick();
    bus_request = 1'b1;
    memdata     = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_fs", 32'(fetch_surpress), 32'h1);
      check("stall_valid", 32'(pipe1_valid), 32'h0);
    end
    bus_request = 1'b0;
    memdata     = 8'h12;
    tick();
    check("stall_imm", 32'(pipe1_imm), 32'h1234);
    check("stall_out", 32'(pipe1_out), 32'h81);
    bus_request = 1'b1;
    tick();
    check("stall_hold_valid", 32'(pipe1_valid), 32'h1);
    bus_request = 1'b0;

    // Back-to-back zero-immediate opcodes.
    pipe0_in = 8'h01;
    tick();
    check("b2b_out0", 32'(pipe1_out), 32'h01);
    pipe0_in = 8'h3F;
    tick();
    check("b2b_out1", 32'(pipe1_out), 32'h3F);
    pipe0_in = 8'hC5;
    tick();
    check("b2b_out2", 32'(pipe1_out), 32'hC5);
    check("b2b_valid2", 32'(pipe1_valid), 32'h1);

    // Flush in the high-byte state.
    pipe0_in = 8'h81;
    tick();
    pipe0_in = 8'h00;
    memdata  = 8'h34;
    tick();
    flush = 1'b1;
    tick();
    check("flush_fs", 32'(fetch_surpress), 32'h0);
    check("flush_valid", 32'(pipe1_valid), 32'h0);
    check("flush_out", 32'(pipe1_out), 32'h00);

    // Flush beats BusRequest, and a flushed cycle captures no opcode.
    flush    = 1'b0;
    pipe0_in = 8'h81;
    tick();
    flush       = 1'b1;
    bus_request = 1'b1;
    tick();
    check("flush_bus_fs", 32'(fetch_surpress), 32'h0);
    check("flush_bus_out", 32'(pipe1_out), 32'h00);
    bus_request = 1'b0;
    pipe0_in    = 8'h05;
    tick();
    check("flush_nocap_valid", 32'(pipe1_valid), 32'h0);
    flush    = 1'b0;
    pipe0_in = 8'h00;
    tick();

`ifdef PIPELINE_STAGE1_BUBBLE_COUNT_EN
    reset_in = 1'b1;
    tick();
    check("bub_rst", 32'(bubble_count), 32'h0);
    reset_in = 1'b0;
    pipe0_in = 8'h81;
    tick();
    memdata = 8'h34;
    tick();
    memdata = 8'h12;
    tick();
    pipe0_in = 8'h42;
    tick();
    pipe0_in = 8'h00;
    memdata  = 8'h7E;
    tick();
    check("bub_three", 32'(bubble_count), 32'h3);
    flush = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("bub_saturate", 32'(bubble_count), 32'hFFFF);
    flush = 1'b0;
    tick();
`endif

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
